// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared types for the register dump reader.
//   state_e        - dump FSM states
//   READ_LAT_*     - the two supported reg_file read latencies
package reg_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int READ_LAT_COMB = 0;  // combinational reg_file read
    localparam int READ_LAT_REG  = 1;  // registered reg_file read

endpackage

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks an inclusive, wrapping register range on one
// reg_file read port and emits each register as an {address, data} beat
// on a valid/ready stream.
// Ports:
//   clk, rst             clock, async active-low reset
//   start                begin a dump (sampled in IDLE only)
//   first_add, last_add  inclusive range, captured on accepted start
//   abort                cancel a dump in progress (no done pulse)
//   readRegAdd           reg_file read address
//   readRegData          reg_file read data
//   out_valid/out_ready  stream handshake
//   out_add, out_data    beat payload
//   busy                 dump in progress
//   done                 one-cycle pulse after the last beat is accepted
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int READ_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_add,
    input  logic [ADDR_W-1:0] last_add,
    input  logic              abort,
    output logic [ADDR_W-1:0] readRegAdd,
    input  logic [WIDTH-1:0]  readRegData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_add,
    output logic [WIDTH-1:0]  out_data,
    output logic              busy,
    output logic              done
);

    // Anything other than the combinational setting is treated as registered.
    localparam bit REG_READ = (READ_LAT != READ_LAT_COMB);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              ovalid_q, ovalid_d;
    logic [ADDR_W-1:0] oadd_q, oadd_d;
    logic [WIDTH-1:0]  odata_q, odata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d  = state_q;
        raddr_d  = raddr_q;
        last_d   = last_q;
        ovalid_d = ovalid_q;
        oadd_d   = oadd_q;
        odata_d  = odata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        // Abort outranks every other transition while a dump is active. A
        // handshake on the same edge has already been seen by the consumer.
        if (abort && (state_q inside {ST_READ, ST_WAIT, ST_SEND})) begin
            state_d  = ST_IDLE;
            ovalid_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        last_d  = last_add;
                        raddr_d = first_add;
                        busy_d  = 1'b1;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    if (REG_READ) begin
                        state_d = ST_WAIT;
                    end else begin
                        odata_d  = readRegData;
                        oadd_d   = raddr_q;
                        ovalid_d = 1'b1;
                        state_d  = ST_SEND;
                    end
                end
                ST_WAIT: begin
                    odata_d  = readRegData;
                    oadd_d   = raddr_q;
                    ovalid_d = 1'b1;
                    state_d  = ST_SEND;
                end
                ST_SEND: begin
                    if (ovalid_q && out_ready) begin
                        ovalid_d = 1'b0;
                        if (oadd_q == last_q) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            // Natural wrap of the ADDR_W-bit counter gives
                            // the modulo range walk.
                            raddr_d = raddr_q + 1'b1;
                            state_d = ST_READ;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: begin
                    state_d  = ST_IDLE;
                    ovalid_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            raddr_q  <= '0;
            last_q   <= '0;
            ovalid_q <= 1'b0;
            oadd_q   <= '0;
            odata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            raddr_q  <= raddr_d;
            last_q   <= last_d;
            ovalid_q <= ovalid_d;
            oadd_q   <= oadd_d;
            odata_q  <= odata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign readRegAdd = raddr_q;
    assign out_valid  = ovalid_q;
    assign out_add    = oadd_q;
    assign out_data   = odata_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: one instance with a combinational reg_file
// read, one with a registered read. Expected beats come from the range
// rule (count = ((last-first) mod 32)+1, addresses wrap) applied to the
// bench's register array; a negedge process checks every handshake,
// hold-while-stalled, valid-rise latency and the done pulse.
module tb_reg_dump_reader;
    localparam int W  = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start0, start1, abort, out_ready;
    logic [AW-1:0] first_add, last_add;
    logic [W-1:0]  mem [32];

    logic [AW-1:0] raddr0, oadd0, raddr1, oadd1;
    logic [W-1:0]  rdata0, odata0, rdata1, odata1;
    logic          v0, busy0, done0, v1, busy1, done1;

    assign rdata0 = mem[raddr0];
    always @(posedge clk) rdata1 <= mem[raddr1];

    reg_dump_reader #(.WIDTH(W), .ADDR_W(AW), .READ_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .first_add(first_add),
        .last_add(last_add), .abort(abort), .readRegAdd(raddr0),
        .readRegData(rdata0), .out_valid(v0), .out_ready(out_ready),
        .out_add(oadd0), .out_data(odata0), .busy(busy0), .done(done0));

    reg_dump_reader #(.WIDTH(W), .ADDR_W(AW), .READ_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .first_add(first_add),
        .last_add(last_add), .abort(1'b0), .readRegAdd(raddr1),
        .readRegData(rdata1), .out_valid(v1), .out_ready(out_ready),
        .out_add(oadd1), .out_data(odata1), .busy(busy1), .done(done1));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- model / scoreboard ----------------
    logic [AW+W-1:0] exp0[$], exp1[$], log0[$], log1[$];
    int cyc = 0, upd0 = 0, upd1 = 0, hs0 = 0, hs1 = 0;
    int done0_cnt = 0, done1_cnt = 0;
    logic [AW-1:0] p_raddr0 = '0, p_raddr1 = '0, p_oadd0 = '0;
    logic [W-1:0]  p_odata0 = '0;
    logic          p_v0 = 1'b0, p_v1 = 1'b0, p_rdy = 1'b0, p_abort = 1'b0;

    task automatic push_exp(input bit which, input logic [AW-1:0] f, input logic [AW-1:0] l);
        logic [AW-1:0] span;
        logic [AW-1:0] a;
        span = l - f;
        for (int i = 0; i <= int'(span); i++) begin
            a = f + AW'(i);
            if (which) exp1.push_back({a, mem[a]});
            else       exp0.push_back({a, mem[a]});
        end
    endtask

    always @(negedge clk) begin
        logic [AW+W-1:0] e;
        cyc++;
        if (rst) begin
            // combinational-read instance
            if (raddr0 != p_raddr0) upd0 = cyc;
            if (v0 && !p_v0) chk("lat0 valid rise after addr", cyc - upd0, 1);
            if (p_v0 && !p_rdy && !p_abort) begin
                chk("lat0 hold valid", v0, 1);
                chk("lat0 hold add", oadd0, p_oadd0);
                chk("lat0 hold data", odata0, p_odata0);
            end
            if (v0) chk("lat0 busy with valid", busy0, 1);
            if (v0 && out_ready) begin
                chk("lat0 beat expected", exp0.size() > 0, 1);
                if (exp0.size() > 0) begin
                    e = exp0.pop_front();
                    chk("lat0 beat add", oadd0, e[AW+W-1:W]);
                    chk("lat0 beat data", odata0, e[W-1:0]);
                end
                log0.push_back({oadd0, odata0});
                hs0 = cyc;
            end
            if (done0) begin
                done0_cnt++;
                chk("lat0 done after last beat", cyc - hs0, 1);
                chk("lat0 busy low at done", busy0, 0);
                chk("lat0 all beats seen at done", exp0.size(), 0);
            end
            // registered-read instance
            if (raddr1 != p_raddr1) upd1 = cyc;
            if (v1 && !p_v1) chk("lat1 valid rise after addr", cyc - upd1, 2);
            if (v1 && out_ready) begin
                chk("lat1 beat expected", exp1.size() > 0, 1);
                if (exp1.size() > 0) begin
                    e = exp1.pop_front();
                    chk("lat1 beat add", oadd1, e[AW+W-1:W]);
                    chk("lat1 beat data", odata1, e[W-1:0]);
                end
                log1.push_back({oadd1, odata1});
                hs1 = cyc;
            end
            if (done1) begin
                done1_cnt++;
                chk("lat1 done after last beat", cyc - hs1, 1);
                chk("lat1 busy low at done", busy1, 0);
                chk("lat1 all beats seen at done", exp1.size(), 0);
            end
        end
        p_raddr0 = raddr0; p_raddr1 = raddr1; p_oadd0 = oadd0; p_odata0 = odata0;
        p_v0 = v0; p_v1 = v1; p_rdy = out_ready; p_abort = abort;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump0(input logic [AW-1:0] f, input logic [AW-1:0] l);
        push_exp(1'b0, f, l);
        first_add = f; last_add = l; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("lat0 busy after start", busy0, 1);
    endtask

    task automatic wait_v0();
        int i = 0;
        while (!v0 && i < 50) begin tick(); i++; end
        chk("lat0 valid reached", v0, 1);
    endtask

    task automatic wait_done0();
        int i = 0;
        while (!done0 && i < 300) begin tick(); i++; end
        chk("lat0 done reached", done0, 1);
        tick();
        chk("lat0 done one cycle", done0, 0);
    endtask

    initial begin : stim
        int base;
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0; out_ready = 1'b1;
        first_add = '0; last_add = '0;
        for (int i = 0; i < 32; i++) mem[i] = W'(i * 16 + 5);
        mem[1] = 111; mem[2] = 0; mem[3] = 333; mem[7] = 777; mem[8] = 888; mem[9] = 999;

        // reset and idle
        #23;
        chk("rst readRegAdd", raddr0, 0);
        chk("rst out_valid", v0, 0);
        chk("rst out_add", oadd0, 0);
        chk("rst out_data", odata0, 0);
        chk("rst busy", busy0, 0);
        chk("rst done", done0, 0);
        chk("rst lat1 valid", v1, 0);
        tick(); rst = 1'b1;
        repeat (5) tick();
        chk("idle valid", v0, 0);
        chk("idle busy", busy0, 0);
        chk("idle no done", done0_cnt, 0);

        // basic dump 1..3
        log0.delete();
        start_dump0(5'd1, 5'd3);
        wait_done0();
        chk("basic beats", log0.size(), 3);
        chk("basic beat0", log0[0], {5'd1, 32'd111});
        chk("basic beat1", log0[1], {5'd2, 32'd0});
        chk("basic beat2", log0[2], {5'd3, 32'd333});
        chk("basic done count", done0_cnt, 1);

        // backpressure on the second beat
        log0.delete();
        out_ready = 1'b0;
        start_dump0(5'd1, 5'd3);
        wait_v0();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        wait_v0();
        chk("bp stalled add", oadd0, 2);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp readRegAdd held", raddr0, 2);
            chk("bp valid held", v0, 1);
        end
        out_ready = 1'b1;
        wait_done0();
        chk("bp beats", log0.size(), 3);
        chk("bp beat1", log0[1], {5'd2, 32'd0});

        // wrap 30..1
        log0.delete();
        start_dump0(5'd30, 5'd1);
        wait_done0();
        chk("wrap beats", log0.size(), 4);
        chk("wrap a0", log0[0][AW+W-1:W], 30);
        chk("wrap a1", log0[1][AW+W-1:W], 31);
        chk("wrap a2", log0[2][AW+W-1:W], 0);
        chk("wrap a3", log0[3][AW+W-1:W], 1);

        // single 7..7
        log0.delete();
        base = done0_cnt;
        start_dump0(5'd7, 5'd7);
        wait_done0();
        chk("single beats", log0.size(), 1);
        chk("single beat", log0[0], {5'd7, 32'd777});
        chk("single done count", done0_cnt, base + 1);

        // abort and start-while-busy: 0..9, only beats 0..2 delivered
        log0.delete();
        base = done0_cnt;
        out_ready = 1'b0;
        push_exp(1'b0, 5'd0, 5'd2);
        first_add = 5'd0; last_add = 5'd9; start0 = 1'b1;
        tick(); start0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_v0();
            out_ready = 1'b1; tick(); out_ready = 1'b0;
            if (k == 0) begin
                first_add = 5'd20; last_add = 5'd25; start0 = 1'b1;
                tick(); start0 = 1'b0;
            end
        end
        wait_v0();
        chk("abort beat4 add", oadd0, 3);
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort valid drop", v0, 0);
        chk("abort busy", busy0, 0);
        repeat (4) tick();
        chk("abort no done", done0_cnt, base);
        chk("abort stays idle", v0, 0);
        chk("abort beats", log0.size(), 3);
        chk("abort pending", exp0.size(), 0);

        // new start accepted after abort
        log0.delete();
        out_ready = 1'b1;
        start_dump0(5'd5, 5'd6);
        wait_done0();
        chk("restart beats", log0.size(), 2);
        chk("restart beat0", log0[0][AW+W-1:W], 5);

        // reset mid-dump
        base = done0_cnt;
        out_ready = 1'b0;
        start_dump0(5'd10, 5'd12);
        wait_v0();
        #2 rst = 1'b0;
        #1;
        chk("midrst valid", v0, 0);
        chk("midrst add", oadd0, 0);
        chk("midrst data", odata0, 0);
        chk("midrst readRegAdd", raddr0, 0);
        chk("midrst busy", busy0, 0);
        exp0.delete();
        tick(); rst = 1'b1;
        repeat (4) tick();
        chk("midrst no done", done0_cnt, base);
        chk("midrst idle", v0, 0);

        // registered read instance, 7..9
        out_ready = 1'b1;
        log1.delete();
        push_exp(1'b1, 5'd7, 5'd9);
        first_add = 5'd7; last_add = 5'd9; start1 = 1'b1;
        tick(); start1 = 1'b0;
        chk("lat1 busy", busy1, 1);
        chk("lat1 valid edge1", v1, 0);
        tick();
        chk("lat1 valid edge2", v1, 0);
        tick();
        chk("lat1 valid edge3", v1, 1);
        chk("lat1 first data", odata1, 777);
        begin
            int i = 0;
            while (!done1 && i < 300) begin tick(); i++; end
        end
        chk("lat1 done reached", done1, 1);
        tick();
        chk("lat1 beats", log1.size(), 3);
        chk("lat1 beat1", log1[1], {5'd8, 32'd888});
        chk("lat1 beat2", log1[2], {5'd9, 32'd999});
        chk("lat1 done count", done1_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
Debug/self-check reader for reg_file. On a start pulse it walks an inclusive address range on one reg_file read port. Each register is emitted as an {address, data} beat on a valid/ready stream. It sits beside the datapath, and the bench and debug logic use it to dump architectural state after a program or test run.

Parameters:
WIDTH, `width, data width of readRegData and out_data
ADDR_W, `logDepthReg, register address width
READ_LAT, 0, reg_file read latency in cycles; legal values are 0 (combinational read) or 1 (registered read)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-low (rst==0 resets)
start  input  1  one-cycle request to begin a dump; sampled only in IDLE
first_add  input  ADDR_W  first register of the range; captured on accepted start
last_add  input  ADDR_W  last register of the range, inclusive; captured on accepted start
abort  input  1  terminates a dump in progress
readRegAdd  output  ADDR_W  address driven to the reg_file read port
readRegData  input  WIDTH  data returned by the reg_file read port
out_valid  output  1  stream beat valid
out_ready  input  1  stream consumer ready
out_add  output  ADDR_W  register address of the current beat
out_data  output  WIDTH  register contents of the current beat
busy  output  1  dump in progress
done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (rst low, async): state IDLE; readRegAdd=0, out_valid=0, out_add=0, out_data=0, busy=0, done=0. Every output is a flop.
- States: IDLE, READ, WAIT (used only when READ_LAT=1), SEND, DONE.
- IDLE: on start=1 at posedge:
  - capture first_add and last_add;
  - readRegAdd<=first_add, busy<=1, go to READ.
- READ:
  - READ_LAT=0: at the next posedge, out_data<=readRegData, out_add<=readRegAdd, out_valid<=1, go to SEND.
  - READ_LAT=1: go to WAIT; in WAIT perform the same capture at the following posedge, then go to SEND.
- SEND:
  - out_valid, out_add and out_data are held stable while out_ready=0.
  - On an edge with out_valid&&out_ready:
    - if out_add==last: out_valid<=0, go to DONE;
    - otherwise readRegAdd<=readRegAdd+1 (mod 2^ADDR_W), out_valid<=0, go to READ.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
- Throughput: one beat per 2 cycles (READ_LAT=0) or per 3 cycles (READ_LAT=1) when out_ready is held at 1.
- Range arithmetic: the address increments modulo 2^ADDR_W.
  - Beat count = ((last-first) mod 2^ADDR_W)+1.
  - first==last gives 1 beat.
  - last<first wraps through the top address back to 0.
- start while busy or in DONE: ignored; it does not queue or restart.
- abort: in READ, WAIT or SEND it takes priority over every other transition.
  - Next state is IDLE with out_valid<=0 and busy<=0; done is not pulsed.
  - A beat that completes its handshake on the same edge as abort is counted as delivered.
  - abort in IDLE or DONE has no effect.
- Reset mid-dump: immediate return to the reset values; no done pulse.
- readRegAdd holds its last value in IDLE and DONE.

Decomposition:
- Package reg_dump_pkg holds:
  - the state enum typedef (IDLE, READ, WAIT, SEND, DONE);
  - the legal READ_LAT values.
- Widths come from `width and `logDepthReg in param.sv.
- No sub-module; a single FSM plus one address counter and one output register set.

Test Plan:
- Reset and idle: hold rst=0 then release; start never asserted -> all outputs stay 0, no beats, done never pulses.
- Basic dump: preload reg1=111, reg2=0, reg3=333; start with first=1, last=3, out_ready=1 -> beats (1,111),(2,0),(3,333) in order; done pulses 1 cycle after the third handshake; busy high from the start edge until DONE.
- Backpressure: same dump with out_ready=0 for 5 cycles on the second beat -> (2,0) held stable, no beat lost or duplicated, readRegAdd stays 2.
- Wrap and single: ADDR_W=5, first=30, last=1 -> exactly 4 beats with addresses 30,31,0,1. Then first=last=7 with reg7=777 -> a single beat (7,777) and one done pulse.
- Abort and start-while-busy:
  - start first=0, last=9, then pulse start again mid-run -> the second start is ignored.
  - abort during SEND of beat 4 with out_ready=0 -> out_valid drops next cycle, no done, busy=0.
  - A new start is then accepted.
- READ_LAT=1: bench reg_file model with a registered read, dump 7..9 with reg7=777, reg9=999 -> data matches, each beat's out_valid rises 2 edges after readRegAdd updates.
